wb_instr_feeder: RTL

//  Wishbone slave that sequences instruction delivery to the core under test. Driver-side pushes
//  32-bit instructions into a FIFO. Each core fetch (stb & !we) pops one entry and returns it
//  as the 128-bit beat {FILL_WORD x3, instr}. Core stores are acked and exposed to the monitor.

---
 rtl/wb_instr_feeder_if.sv | 48 ++++
 rtl/wb_instr_feeder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_instr_feeder_if.sv
// Bus bundle between the instruction feeder and its bench driver/monitor plus the core's Wishbone port.
// DEPTH must match the feeder so the occupancy field has the right width.
interface wb_instr_feeder_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             i_inst_valid;
    logic [31:0]      i_inst;
    logic             o_inst_ready;

    logic             i_wb_cyc;
    logic             i_wb_stb;
    logic             i_wb_we;
    logic [31:0]      i_wb_adr;
    logic [15:0]      i_wb_sel;
    logic [127:0]     i_wb_dat;
    logic [127:0]     o_wb_dat;
    logic             o_wb_ack;
    logic             o_wb_err;

    logic             o_wr_valid;
    logic [31:0]      o_wr_adr;
    logic [15:0]      o_wr_sel;
    logic [127:0]     o_wr_dat;

    logic [LVL_W-1:0] o_level;
    logic [15:0]      o_fetch_cnt;

    // The feeder is the Wishbone slave; the driver/core side is the master.
    modport slave (
        input  i_inst_valid, i_inst,
        output o_inst_ready,
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_sel, i_wb_dat,
        output o_wb_dat, o_wb_ack, o_wb_err,
        output o_wr_valid, o_wr_adr, o_wr_sel, o_wr_dat,
        output o_level, o_fetch_cnt
    );

    modport master (
        output i_inst_valid, i_inst,
        input  o_inst_ready,
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_sel, i_wb_dat,
        input  o_wb_dat, o_wb_ack, o_wb_err,
        input  o_wr_valid, o_wr_adr, o_wr_sel, o_wr_dat,
        input  o_level, o_fetch_cnt
    );
endinterface

// File: rtl/wb_instr_feeder.sv
// Wishbone slave that feeds queued 32-bit instructions to a core as padded 128-bit read beats.
// Define WB_FEEDER_ERR_EN to error out a read that waits STALL_LIMIT cycles on an empty queue.
module wb_instr_feeder #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] FILL_WORD   = 32'hF0081003,
    parameter int unsigned STALL_LIMIT = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    wb_instr_feeder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STALL_LIMIT < 1 || STALL_LIMIT > 256) begin : g_bad_param
        $error("wb_instr_feeder: DEPTH must be a power of 2 >= 2 and STALL_LIMIT in 1..256");
    end

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        ACK
    } State_e;

    State_e           state_q;
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [127:0]     rdDat_q;
    logic             ack_q;
    logic             wrValid_q;
    logic [31:0]      wrAdr_q;
    logic [15:0]      wrSel_q;
    logic [127:0]     wrDat_q;
    logic [15:0]      fetchCnt_q;

`ifdef WB_FEEDER_ERR_EN
    logic             err_q;
    logic [7:0]       stallCnt_q;
`endif

    logic readReq;
    logic writeReq;
    logic notEmpty;
    logic notFull;
    logic push;
    logic pop;

    // A pop happens exactly when the FSM accepts a read with data available, in IDLE or STALL.
    always_comb begin
        readReq  = bus.i_wb_cyc & bus.i_wb_stb & ~bus.i_wb_we;
        writeReq = bus.i_wb_cyc & bus.i_wb_stb & bus.i_wb_we;
        notEmpty = (level_q != '0);
        notFull  = (level_q != LVL_W'(DEPTH));
        push     = bus.i_inst_valid & notFull;
        pop      = readReq & notEmpty & ((state_q == IDLE) || (state_q == STALL));
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= bus.i_inst;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            rdDat_q    <= '0;
            ack_q      <= 1'b0;
            wrValid_q  <= 1'b0;
            wrAdr_q    <= '0;
            wrSel_q    <= '0;
            wrDat_q    <= '0;
            fetchCnt_q <= '0;
`ifdef WB_FEEDER_ERR_EN
            err_q      <= 1'b0;
            stallCnt_q <= '0;
`endif
        end else begin
            ack_q     <= 1'b0;
            wrValid_q <= 1'b0;
`ifdef WB_FEEDER_ERR_EN
            err_q     <= 1'b0;
`endif
            level_q   <= level_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q    <= rdPtr_q + PTR_W'(1);
                rdDat_q    <= {{3{FILL_WORD}}, mem_q[rdPtr_q]};
                ack_q      <= 1'b1;
                fetchCnt_q <= fetchCnt_q + 16'd1;
            end

            case (state_q)
                IDLE: begin
                    if (writeReq) begin
                        wrAdr_q   <= bus.i_wb_adr;
                        wrSel_q   <= bus.i_wb_sel;
                        wrDat_q   <= bus.i_wb_dat;
                        wrValid_q <= 1'b1;
                        ack_q     <= 1'b1;
                        state_q   <= ACK;
                    end else if (readReq) begin
                        state_q <= notEmpty ? ACK : STALL;
`ifdef WB_FEEDER_ERR_EN
                        stallCnt_q <= '0;
`endif
                    end
                end
                // A dropped strobe, or a switch to a store, abandons the wait without popping.
                STALL: begin
                    if (!readReq) begin
                        state_q <= IDLE;
                    end else if (notEmpty) begin
                        state_q <= ACK;
`ifdef WB_FEEDER_ERR_EN
                    end else if (stallCnt_q == 8'(STALL_LIMIT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        stallCnt_q <= stallCnt_q + 8'd1;
`endif
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_inst_ready = notFull;
    assign bus.o_wb_dat     = rdDat_q;
    assign bus.o_wb_ack     = ack_q;
    assign bus.o_wr_valid   = wrValid_q;
    assign bus.o_wr_adr     = wrAdr_q;
    assign bus.o_wr_sel     = wrSel_q;
    assign bus.o_wr_dat     = wrDat_q;
    assign bus.o_level      = level_q;
    assign bus.o_fetch_cnt  = fetchCnt_q;
`ifdef WB_FEEDER_ERR_EN
    assign bus.o_wb_err     = err_q;
`else
    assign bus.o_wb_err     = 1'b0;
`endif

endmodule
